// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB-first, optional parity, one stop bit.
// Bit timing uses a BAUD_MAX+1 cycle baud counter that matches the sister receiver.
module uart_tx #(
  parameter int BAUD_MAX = 5207,
  parameter int PARITY   = 0
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_trig,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [12:0] BAUD_TC = 13'(BAUD_MAX);

  state_t      state_reg;
  logic [12:0] baud_cnt_reg;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic        parity_reg;
  logic        tx_reg;
  logic        tx_busy_reg;
  logic        tx_done_reg;
  logic        baud_tc;

  assign baud_tc = (baud_cnt_reg == BAUD_TC);

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      tx_busy_reg  <= 1'b0;
      tx_done_reg  <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;
      if (state_reg != S_IDLE) begin
        baud_cnt_reg <= baud_tc ? 13'd0 : baud_cnt_reg + 13'd1;
      end
      case (state_reg)
        S_IDLE: begin
          baud_cnt_reg <= '0;
          tx_reg       <= 1'b1;
          tx_busy_reg  <= 1'b0;
          if (tx_trig) begin
            shift_reg   <= tx_data;
            // Odd parity makes the total count of ones odd, hence the inverted XOR.
            parity_reg  <= (PARITY == 1) ? ~^tx_data : ^tx_data;
            state_reg   <= S_START;
            tx_reg      <= 1'b0;
            tx_busy_reg <= 1'b1;
          end
        end
        S_START: begin
          if (baud_tc) begin
            state_reg   <= S_DATA;
            bit_cnt_reg <= '0;
            tx_reg      <= shift_reg[0];
          end
        end
        S_DATA: begin
          if (baud_tc) begin
            shift_reg   <= shift_reg >> 1;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if (PARITY != 0) begin
                state_reg <= S_PARITY;
                tx_reg    <= parity_reg;
              end else begin
                state_reg <= S_STOP;
                tx_reg    <= 1'b1;
              end
            end else begin
              // The next bit is loaded at the boundary so tx stays a pure flop output.
              tx_reg <= shift_reg[1];
            end
          end
        end
        S_PARITY: begin
          if (baud_tc) begin
            state_reg <= S_STOP;
            tx_reg    <= 1'b1;
          end
        end
        S_STOP: begin
          if (baud_tc) begin
            state_reg   <= S_IDLE;
            tx_busy_reg <= 1'b0;
            tx_done_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign tx      = tx_reg;
  assign tx_busy = tx_busy_reg;
  assign tx_done = tx_done_reg;

endmodule
